mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execution stage.
- Registers the ALU result and N/Z/C/V flags each instruction.
- For load and store instructions, performs one data-memory access through a req/gnt/rvalid interface, using the ALU result as the address.
- Presents the writeback payload to the writeback stage through a valid/ready handshake and holds the architectural flags register.

---
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: registers the ALU result and flags, performs at most one
// data-memory access per load/store over a req/gnt/rvalid interface, and
// hands the writeback payload on through a valid/ready handshake.
module mem_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [3:0]        flags_in,
  input  logic              set_flags,
  input  logic [1:0]        mem_op,
  input  logic [REG_W-1:0]  dest_in,
  input  logic              wb_en_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dest,
  output logic              wb_en,
  output logic [3:0]        flags_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [REG_W-1:0]    wb_dest_q, wb_dest_d;
  logic                wb_en_q, wb_en_d;
  logic [3:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_store_q, is_store_d;
  logic [REG_W-1:0]    pend_dest_q, pend_dest_d;
  logic                pend_wb_en_q, pend_wb_en_d;
  logic                accept;
  logic                is_mem_op;

  // New work is taken only when idle and the output slot is free or draining.
  assign in_ready  = !rst && !flush && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mem_op = (mem_op == 2'b01) || (mem_op == 2'b10);

  assign out_valid  = out_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_dest    = wb_dest_q;
  assign wb_en      = wb_en_q;
  assign flags_out  = flags_q;
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = (state_q == REQ) && is_store_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  // Next-state, capture and writeback payload selection.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    wb_data_d    = wb_data_q;
    wb_dest_d    = wb_dest_q;
    wb_en_d      = wb_en_q;
    flags_d      = flags_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_store_d   = is_store_q;
    pend_dest_d  = pend_dest_q;
    pend_wb_en_d = pend_wb_en_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      wb_data_d   = '0;
      wb_dest_d   = '0;
      wb_en_d     = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d       = alu_result;
          wdata_d      = store_data;
          is_store_d   = (mem_op == 2'b10);
          pend_dest_d  = dest_in;
          pend_wb_en_d = wb_en_in;
          if (set_flags) begin
            flags_d = flags_in;
          end
          if (is_mem_op) begin
            state_d = REQ;
          end else begin
            out_valid_d = 1'b1;
            wb_data_d   = alu_result;
            wb_dest_d   = dest_in;
            wb_en_d     = wb_en_in;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (is_store_q) begin
            state_d = IDLE;
            if (!flush) begin
              out_valid_d = 1'b1;
              wb_data_d   = addr_q;
              wb_dest_d   = pend_dest_q;
              wb_en_d     = 1'b0;
            end
          end else begin
            state_d = flush ? DRAIN : WAIT;
          end
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
          if (!flush) begin
            out_valid_d = 1'b1;
            wb_data_d   = dmem_rdata;
            wb_dest_d   = pend_dest_q;
            wb_en_d     = pend_wb_en_q;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      out_valid_d = 1'b0;
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      wb_data_q    <= '0;
      wb_dest_q    <= '0;
      wb_en_q      <= 1'b0;
      flags_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_store_q   <= 1'b0;
      pend_dest_q  <= '0;
      pend_wb_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      wb_data_q    <= wb_data_d;
      wb_dest_q    <= wb_dest_d;
      wb_en_q      <= wb_en_d;
      flags_q      <= flags_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_store_q   <= is_store_d;
      pend_dest_q  <= pend_dest_d;
      pend_wb_en_q <= pend_wb_en_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table of single-instruction vectors plus hand-written
// sequences for back-to-back issue, output back-pressure, flush and reset.
// Writeback results are checked through an in-order scoreboard.
module tb_mem_stage;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [3:0]        flags_in;
  logic              set_flags;
  logic [1:0]        mem_op;
  logic [REG_W-1:0]  dest_in;
  logic              wb_en_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_dest;
  logic              wb_en;
  logic [3:0]        flags_out;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;

  typedef struct {
    logic [1:0]        mem_op;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
    logic [DATA_W-1:0] rdata;
    logic [REG_W-1:0]  dest;
    logic              wb_en_in;
    logic              set_flags;
    logic [3:0]        flags_in;
    int                gnt_dly;
    int                rv_dly;
    logic [DATA_W-1:0] exp_data;
    logic              exp_en;
    logic [3:0]        exp_flags;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  dest;
    logic              en;
    logic              chk_data;
  } sb_t;

  int  checks = 0;
  int  fails  = 0;
  sb_t exp_q[$];
  vec_t vecs[8];

  mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data),
    .flags_in(flags_in), .set_flags(set_flags), .mem_op(mem_op),
    .dest_in(dest_in), .wb_en_in(wb_en_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_dest(wb_dest), .wb_en(wb_en), .flags_out(flags_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic [1:0] op, input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd,
                       input logic [REG_W-1:0] dst, input logic en, input logic sf, input logic [3:0] f);
    mem_op     = op;
    alu_result = alu;
    store_data = sd;
    dest_in    = dst;
    wb_en_in   = en;
    set_flags  = sf;
    flags_in   = f;
    in_valid   = 1'b1;
    #1;
  endtask

  task automatic pushExp(input logic [DATA_W-1:0] d, input logic [REG_W-1:0] dst, input logic en, input logic cd);
    sb_t e;
    e.data = d; e.dest = dst; e.en = en; e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every completed writeback handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_output: got wb_data 0x%0h dest %0d, expected none", wb_data, wb_dest);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        if (e.chk_data) checkOutput("sb_wb_data", wb_data, e.data);
        checkOutput("sb_wb_dest", DATA_W'(wb_dest), DATA_W'(e.dest));
        checkOutput("sb_wb_en", DATA_W'(wb_en), DATA_W'(e.en));
      end
    end
  end

  // Runs one table vector through accept, memory handshake and completion.
  task automatic applyStimulus(input vec_t v);
    bit mem;
    mem = (v.mem_op == 2'b01) || (v.mem_op == 2'b10);
    setOp(v.mem_op, v.alu, v.sdata, v.dest, v.wb_en_in, v.set_flags, v.flags_in);
    checkOutput("in_ready_at_accept", DATA_W'(in_ready), 1);
    pushExp(v.exp_data, v.dest, v.exp_en, v.mem_op != 2'b10);
    step();
    in_valid = 1'b0;
    checkOutput("flags_after_accept", DATA_W'(flags_out), DATA_W'(v.exp_flags));
    if (mem) begin
      for (int i = 0; i <= v.gnt_dly; i++) begin
        checkOutput("req_we", DATA_W'({dmem_req, dmem_we}), DATA_W'({1'b1, v.mem_op == 2'b10}));
        checkOutput("req_addr", dmem_addr, v.alu);
        if (v.mem_op == 2'b10) checkOutput("req_wdata", dmem_wdata, v.sdata);
        checkOutput("in_ready_busy", DATA_W'(in_ready), 0);
        checkOutput("out_valid_busy", DATA_W'(out_valid), 0);
        if (i == v.gnt_dly) dmem_gnt = 1'b1;
        step();
      end
      dmem_gnt = 1'b0;
      if (v.mem_op == 2'b01) begin
        for (int i = 0; i <= v.rv_dly; i++) begin
          checkOutput("req_dropped", DATA_W'(dmem_req), 0);
          checkOutput("in_ready_wait", DATA_W'(in_ready), 0);
          checkOutput("out_valid_wait", DATA_W'(out_valid), 0);
          if (i == v.rv_dly) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = v.rdata;
          end
          step();
        end
        dmem_rvalid = 1'b0;
        dmem_rdata  = {$urandom, $urandom};
      end
    end
    checkOutput("out_valid_done", DATA_W'(out_valid), 1);
    checkOutput("flags_done", DATA_W'(flags_out), DATA_W'(v.exp_flags));
  endtask

  initial begin
    // mem_op, alu, sdata, rdata, dest, wb_en_in, set_flags, flags_in, gnt_dly, rv_dly, exp_data, exp_en, exp_flags
    vecs[0] = '{2'b00, 64'h1234, 64'h0, 64'h0, 5'd3, 1'b1, 1'b1, 4'b0100, 0, 0, 64'h1234, 1'b1, 4'b0100};
    vecs[1] = '{2'b11, 64'hABCD, 64'h0, 64'h0, 5'd7, 1'b1, 1'b0, 4'b1111, 0, 0, 64'hABCD, 1'b1, 4'b0100};
    vecs[2] = '{2'b01, 64'h40, 64'h0, 64'hDEAD, 5'd5, 1'b1, 1'b1, 4'b1010, 2, 0, 64'hDEAD, 1'b1, 4'b1010};
    vecs[3] = '{2'b10, 64'h80, 64'hBEEF, 64'h0, 5'd6, 1'b1, 1'b0, 4'b0000, 0, 0, 64'h80, 1'b0, 4'b1010};
    vecs[4] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1'b1, 1'b1, 4'b0001, 0, 0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'b0001};
    vecs[5] = '{2'b01, 64'h3, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd0, 1'b0, 1'b0, 4'b1111, 1, 2,
                64'h0123_4567_89AB_CDEF, 1'b0, 4'b0001};
    vecs[6] = '{2'b10, 64'h7, 64'h0, 64'h0, 5'd12, 1'b1, 1'b1, 4'b0110, 3, 0, 64'h7, 1'b0, 4'b0110};
    vecs[7] = '{2'b00, 64'h0, 64'h0, 64'h0, 5'd31, 1'b0, 1'b1, 4'b0000, 0, 0, 64'h0, 1'b0, 4'b0000};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    setOp(2'b00, 64'h99, 64'h0, 5'd1, 1'b1, 1'b1, 4'b1111);
    step();
    step();
    checkOutput("rst_in_ready", DATA_W'(in_ready), 0);
    in_valid = 1'b0;
    checkOutput("rst_out_valid", DATA_W'(out_valid), 0);
    checkOutput("rst_flags", DATA_W'(flags_out), 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_wb_dest_en", DATA_W'({wb_dest, wb_en}), 0);
    checkOutput("rst_dmem", DATA_W'({dmem_req, dmem_we}), 0);
    checkOutput("rst_dmem_addr", dmem_addr, 0);
    checkOutput("rst_dmem_wdata", dmem_wdata, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", DATA_W'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end
    step();

    $display("[TB] back-to-back non-memory ops");
    for (int k = 1; k <= 3; k++) begin
      setOp(2'b00, DATA_W'(k), 64'h0, REG_W'(k), 1'b1, 1'b0, 4'b0000);
      checkOutput("b2b_in_ready", DATA_W'(in_ready), 1);
      pushExp(DATA_W'(k), REG_W'(k), 1'b1, 1'b1);
      step();
      checkOutput("b2b_out_valid", DATA_W'(out_valid), 1);
      checkOutput("b2b_wb_data", wb_data, DATA_W'(k));
    end
    in_valid = 1'b0;
    step();
    checkOutput("b2b_drained", DATA_W'(out_valid), 0);

    $display("[TB] output back-pressure");
    out_ready = 1'b0;
    setOp(2'b00, 64'h55, 64'h0, 5'd9, 1'b1, 1'b0, 4'b0000);
    checkOutput("hold_first_accept", DATA_W'(in_ready), 1);
    pushExp(64'h55, 5'd9, 1'b1, 1'b1);
    step();
    setOp(2'b00, 64'h66, 64'h0, 5'd10, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold_in_ready", DATA_W'(in_ready), 0);
      checkOutput("hold_out_valid", DATA_W'(out_valid), 1);
      checkOutput("hold_wb_data", wb_data, 64'h55);
      checkOutput("hold_wb_dest", DATA_W'(wb_dest), 9);
      step();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("hold_release_in_ready", DATA_W'(in_ready), 1);
    pushExp(64'h66, 5'd10, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    checkOutput("hold_second_data", wb_data, 64'h66);
    step();

    $display("[TB] flush during WAIT");
    setOp(2'b01, 64'h100, 64'h0, 5'd4, 1'b1, 1'b0, 4'b0000);
    step();
    in_valid = 1'b0;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    flush = 1'b1;
    setOp(2'b00, 64'h77, 64'h0, 5'd2, 1'b1, 1'b0, 4'b0000);
    checkOutput("flush_blocks_accept", DATA_W'(in_ready), 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("drain_in_ready_1", DATA_W'(in_ready), 0);
    checkOutput("drain_out_valid", DATA_W'(out_valid), 0);
    step();
    checkOutput("drain_in_ready_2", DATA_W'(in_ready), 0);
    dmem_rvalid = 1'b1; dmem_rdata = 64'h999;
    step();
    dmem_rvalid = 1'b0;
    checkOutput("drain_done_out_valid", DATA_W'(out_valid), 0);
    checkOutput("drain_done_in_ready", DATA_W'(in_ready), 1);

    $display("[TB] flush during REQ without grant");
    setOp(2'b01, 64'h300, 64'h0, 5'd8, 1'b1, 1'b0, 4'b0000);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checkOutput("req_flush_req", DATA_W'(dmem_req), 0);
    checkOutput("req_flush_in_ready", DATA_W'(in_ready), 1);
    dmem_rvalid = 1'b1; dmem_rdata = 64'hBAD;
    step();
    dmem_rvalid = 1'b0;
    checkOutput("stray_rvalid_out_valid", DATA_W'(out_valid), 0);

    $display("[TB] flush during REQ with grant on a store");
    setOp(2'b10, 64'h200, 64'h11, 5'd9, 1'b1, 1'b0, 4'b0000);
    step();
    in_valid = 1'b0;
    checkOutput("flush_store_req", DATA_W'({dmem_req, dmem_we}), 3);
    flush = 1'b1; dmem_gnt = 1'b1;
    step();
    flush = 1'b0; dmem_gnt = 1'b0;
    #1;
    checkOutput("flush_store_out_valid", DATA_W'(out_valid), 0);
    checkOutput("flush_store_in_ready", DATA_W'(in_ready), 1);
    checkOutput("flush_store_req_drop", DATA_W'(dmem_req), 0);
    step();

    $display("[TB] reset during REQ");
    setOp(2'b01, 64'h400, 64'h0, 5'd3, 1'b1, 1'b1, 4'b1001);
    step();
    in_valid = 1'b0;
    checkOutput("pre_rst_flags", DATA_W'(flags_out), 4'b1001);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready", DATA_W'(in_ready), 0);
    step();
    checkOutput("mid_rst_req", DATA_W'(dmem_req), 0);
    checkOutput("mid_rst_flags", DATA_W'(flags_out), 0);
    checkOutput("mid_rst_addr", dmem_addr, 0);
    rst = 1'b0;
    #1;
    checkOutput("after_mid_rst_in_ready", DATA_W'(in_ready), 1);
    step();
    step();

    checkOutput("scoreboard_empty", DATA_W'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
